// File: rtl/seg_display_ctrl_if.sv
// CPU-side signals consumed by the 7-segment display controller:
// the syscall LED write strobe/word and the four performance counters.
interface seg_display_ctrl_if;
    logic        led_cpu_enable;
    logic [31:0] led_data_in;
    logic [31:0] total_cycles;
    logic [31:0] uncondi_branch_num;
    logic [31:0] condi_branch_num;
    logic [31:0] bubble_num;

    // CPU side drives the values
    modport master (
        output led_cpu_enable,
        output led_data_in,
        output total_cycles,
        output uncondi_branch_num,
        output condi_branch_num,
        output bubble_num
    );

    // Display controller only observes them
    modport slave (
        input led_cpu_enable,
        input led_data_in,
        input total_cycles,
        input uncondi_branch_num,
        input condi_branch_num,
        input bubble_num
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// 8-digit multiplexed 7-segment display driver.
// A debounced push-button cycles through five 32-bit sources (LED word and
// four performance counters). The selected value is snapshotted once per scan
// frame so a frame never mixes digits from two different values.
module seg_display_ctrl #(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DP_HOLD         = 50000000
) (
    input  logic                     clk,
    input  logic                     rst,
    seg_display_ctrl_if.slave        cpu,
    input  logic                     sel_btn,
    output logic [7:0]               an,
    output logic [7:0]               seg,
    output logic [2:0]               mode
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DBC_W = $clog2(DEBOUNCE_CYCLES);
    // The timer is loaded with DP_HOLD itself, so it needs room for that value.
    localparam int DP_W  = $clog2(DP_HOLD + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DP_W-1:0]  DP_LOAD  = DP_W'(DP_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_PRESSED,
        ST_WAIT_RELEASE
    } dbc_state_t;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] f_hex(input logic [3:0] nib);
        case (nib)
            4'h0: f_hex = 7'h3F;
            4'h1: f_hex = 7'h06;
            4'h2: f_hex = 7'h5B;
            4'h3: f_hex = 7'h4F;
            4'h4: f_hex = 7'h66;
            4'h5: f_hex = 7'h6D;
            4'h6: f_hex = 7'h7D;
            4'h7: f_hex = 7'h07;
            4'h8: f_hex = 7'h7F;
            4'h9: f_hex = 7'h6F;
            4'hA: f_hex = 7'h77;
            4'hB: f_hex = 7'h7C;
            4'hC: f_hex = 7'h39;
            4'hD: f_hex = 7'h5E;
            4'hE: f_hex = 7'h79;
            default: f_hex = 7'h71;
        endcase
    endfunction

    // Source mux; indices above 4 never occur, they fall back to the LED word.
    function automatic logic [31:0] f_select(
        input logic [2:0]  m,
        input logic [31:0] s0,
        input logic [31:0] s1,
        input logic [31:0] s2,
        input logic [31:0] s3,
        input logic [31:0] s4
    );
        case (m)
            3'd1:    f_select = s1;
            3'd2:    f_select = s2;
            3'd3:    f_select = s3;
            3'd4:    f_select = s4;
            default: f_select = s0;
        endcase
    endfunction

    logic             r_sync1;
    logic             r_sync2;
    dbc_state_t       r_state;
    dbc_state_t       w_state_nxt;
    logic [DBC_W-1:0] r_dbc;
    logic [DBC_W-1:0] w_dbc_nxt;
    logic             w_press;

    logic [2:0]       r_mode;
    logic [2:0]       w_mode_nxt;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;
    logic [31:0]      r_disp_val;
    logic [DP_W-1:0]  r_dp_timer;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;

    logic [31:0]      w_src_cur;
    logic [31:0]      w_src_nxt;
    logic [3:0]       w_nibble;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sel_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM state and stability counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_dbc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dbc   <= w_dbc_nxt;
        end
    end

    // Debounce next-state: a press is accepted only after DEBOUNCE_CYCLES of stable
    // high, and re-armed only after DEBOUNCE_CYCLES of stable low.
    always_comb begin
        w_state_nxt = r_state;
        w_dbc_nxt   = r_dbc;
        w_press     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = ST_WAIT_PRESS;
                    w_dbc_nxt   = '0;
                end
            end
            ST_WAIT_PRESS: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_dbc == DBC_LAST) begin
                    w_state_nxt = ST_PRESSED;
                end else begin
                    w_dbc_nxt = r_dbc + 1'b1;
                end
            end
            ST_PRESSED: begin
                w_press     = 1'b1;
                w_state_nxt = ST_WAIT_RELEASE;
                w_dbc_nxt   = '0;
            end
            ST_WAIT_RELEASE: begin
                if (r_sync2) begin
                    w_dbc_nxt = '0;
                end else if (r_dbc == DBC_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_dbc_nxt = r_dbc + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_dbc_nxt   = '0;
            end
        endcase
    end

    // Next mode and the current/next source values.
    always_comb begin
        w_mode_nxt = (r_mode == 3'd4) ? 3'd0 : r_mode + 3'd1;
        w_src_cur  = f_select(r_mode, cpu.led_data_in, cpu.total_cycles,
                              cpu.uncondi_branch_num, cpu.condi_branch_num, cpu.bubble_num);
        w_src_nxt  = f_select(w_mode_nxt, cpu.led_data_in, cpu.total_cycles,
                              cpu.uncondi_branch_num, cpu.condi_branch_num, cpu.bubble_num);
        w_nibble   = r_disp_val[{r_idx, 2'b00} +: 4];
    end

    // Mode, scan divider, digit index and frame snapshot; a press restarts the
    // scan and reloads immediately, taking priority over a frame wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode     <= 3'd0;
            r_div      <= '0;
            r_idx      <= 3'd0;
            r_disp_val <= 32'd0;
        end else if (w_press) begin
            r_mode     <= w_mode_nxt;
            r_div      <= '0;
            r_idx      <= 3'd0;
            r_disp_val <= w_src_nxt;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
                r_disp_val <= w_src_cur;
            end
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Decimal-point hold timer: retriggers on every LED write, otherwise counts down to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dp_timer <= '0;
        end else if (cpu.led_cpu_enable) begin
            r_dp_timer <= DP_LOAD;
        end else if (r_dp_timer != '0) begin
            r_dp_timer <= r_dp_timer - 1'b1;
        end
    end

    // Registered active-low digit enables and segments for the current digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= ~(8'b1 << r_idx);
            r_seg <= {~((r_idx == 3'd0) && (r_dp_timer != '0)), ~f_hex(w_nibble)};
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign mode = r_mode;

endmodule
